tsu_axis_tx: RTL
================

Name: tsu_axis_tx

Overview:
- Transmit-side timestamp unit; mirror of the RX TSU on the MAC egress path.
- Sits between the user/DMA TX AXI-stream and the MAC TX AXI-stream. Data passes through combinationally with no added latency.
- Snoops each frame for PTP event messages (EtherType 0x88F7, optionally behind a single 802.1Q tag) and captures the PTP time at the first accepted beat.
- Pushes {timestamp, messageType, sequenceId} records into a small FIFO that the PTP engine reads.

Parameters:
- DATA_WIDTH, 8, stream width; only 8 is supported.
- FIFO_DEPTH, 4, number of timestamp records buffered; must be a power of two, 2..16.
- TS_OFFSET, 0, 64-bit egress latency constant added to every captured timestamp.

Ports:
- mac_axis_aclk  in  1  the single clock; the stream and rtc_timer_in are both in this domain.
- rst_n  in  1  asynchronous, active-low reset.
- user_axis_tdata  in  8  frame byte from the user side.
- user_axis_tvalid  in  1  byte valid.
- user_axis_tlast  in  1  last byte of the frame.
- user_axis_tready  out  1  equals mac_axis_tready.
- mac_axis_tdata  out  8  equals user_axis_tdata.
- mac_axis_tvalid  out  1  equals user_axis_tvalid.
- mac_axis_tlast  out  1  equals user_axis_tlast.
- mac_axis_tready  in  1  ready from the MAC.
- rtc_timer_in  in  64  PTP time in ns, already synchronised to mac_axis_aclk.
- ts_valid  out  1  a record is available at the FIFO head.
- ts_ready  in  1  pop the head record.
- ts_time  out  64  captured timestamp plus TS_OFFSET.
- ts_msg_type  out  4  PTP messageType.
- ts_seq_id  out  16  PTP sequenceId.
- ts_vlan  out  1  the frame carried an 802.1Q tag.
- ts_overflow_cnt  out  16  count of dropped records; saturates at 0xFFFF.

Behaviour:
- Beat = user_axis_tvalid && mac_axis_tready. The block never stalls or alters the stream.
- Reset (async assert, sync release): FSM to IDLE, byte counter 0, FIFO empty, ts_valid 0, ts_time/ts_msg_type/ts_seq_id/ts_vlan 0, ts_overflow_cnt 0.
- FSM IDLE:
  - On a beat: latch t_cap = rtc_timer_in + TS_OFFSET (mod 2^64), set byte counter to 1, clear all parse flags.
  - Go to HDR. If tlast is also set (1-byte frame), stay in IDLE with no push.
- FSM HDR: on each beat, byte counter increments, saturating at 63. Byte index n = counter value before the increment.
  - n=12,13: compare with 0x8100. On match set vlan, and the header base becomes 18; otherwise the base is 14.
  - n=base-2, base-1: compare with 0x88F7. On match set is_ptp.
  - n=base: msg_type = byte[3:0]. is_event = is_ptp && msg_type < 4.
  - n=base+30, base+31: seq_id = {hi, lo}. Set hdr_done after base+31.
  - Once n exceeds base+31, or is_ptp is clear after the EtherType, go to PAYLOAD.
  - A beat with tlast goes to IDLE and applies the push rule.
- FSM PAYLOAD: waits for a beat with tlast, then goes to IDLE and applies the push rule.
- Push rule at the tlast beat: push iff is_event && hdr_done. Runt and non-event frames push nothing.
- Push/pop latency: the record appears at the FIFO head and ts_valid rises on the cycle after the tlast beat. FIFO output is registered and first-word-fall-through.
- Pop: ts_valid && ts_ready. The head advances next cycle.
- Full FIFO:
  - A push with no pop drops the new record and increments ts_overflow_cnt. The FIFO content is unchanged.
  - A push with a simultaneous pop is accepted.
- Empty FIFO: ts_ready is ignored. A push on an empty FIFO gives ts_valid=1 next cycle.
- Idle gaps: user_axis_tvalid low mid-frame holds all state. mac_axis_tready low holds state, and no bytes are counted.
- rst_n asserted mid-frame: the partial frame is discarded and no record is pushed. After release, parsing restarts at the next beat, treated as a start of frame.
- rtc_timer_in wrap: TS_OFFSET addition is modulo 2^64; there is no saturation.

Test Plan:
- Untagged Sync: EtherType 0x88F7, byte14=0x00, seq bytes 44,45 = 0x12,0x34, 60-byte frame, rtc_timer_in=1000 at the first beat, TS_OFFSET=0 -> one cycle after tlast: ts_valid=1, ts_time=1000, ts_msg_type=0, ts_seq_id=0x1234, ts_vlan=0. Stream is bit-identical at the mac side.
- VLAN-tagged Pdelay_Req: bytes 12..13=0x8100, 16..17=0x88F7, byte18=0x02, seq bytes 48,49=0xBE,0xEF -> record msg_type=2, seq_id=0xBEEF, ts_vlan=1.
- Non-event and non-PTP frames: Follow_Up (byte14=0x08), or EtherType 0x0800, or the 61-byte frame with 0x0000 at bytes 12..13 -> ts_valid stays 0.
- Runt PTP frame ending at byte 30 -> no record. The following valid Sync frame yields exactly one record.
- Overflow: FIFO_DEPTH=4, 6 back-to-back Sync frames, ts_ready=0 -> 4 records in order, ts_overflow_cnt=2. Then pop with ts_ready=1 for 4 cycles -> the same seq_ids come out in order, and ts_valid falls after the 4th pop.
- Backpressure and reset: mac_axis_tready toggled every other cycle during a Sync frame -> correct seq_id. rst_n pulsed low at byte 20 of a Sync frame -> no record, and ts_overflow_cnt=0.

Source files
------------

// File: rtl/tsu_axis_tx_if.sv
// Byte-wide AXI-stream bundle used on both sides of the TX timestamp unit.
// The master drives data/valid/last and the slave returns ready.
interface tsu_axis_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tsu_axis_tx.sv
// Egress PTP timestamp unit: passes the TX stream through untouched, parses each
// frame for PTP event messages and queues {time, type, seqId, vlan} records.
module tsu_axis_tx #(
    parameter int          DATA_WIDTH = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [63:0] TS_OFFSET  = 64'd0
) (
    input  logic        mac_axis_aclk,
    input  logic        rst_n,
    tsu_axis_if.slave   user_axis,
    tsu_axis_if.master  mac_axis,
    input  logic [63:0] rtc_timer_in,
    output logic        ts_valid,
    input  logic        ts_ready,
    output logic [63:0] ts_time,
    output logic [3:0]  ts_msg_type,
    output logic [15:0] ts_seq_id,
    output logic        ts_vlan,
    output logic [15:0] ts_overflow_cnt
);
    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD} state_t;

    typedef struct packed {
        logic [63:0] t;
        logic [3:0]  mt;
        logic [15:0] seq;
        logic        vlan;
    } rec_t;

    assign mac_axis.tdata   = user_axis.tdata;
    assign mac_axis.tvalid  = user_axis.tvalid;
    assign mac_axis.tlast   = user_axis.tlast;
    assign user_axis.tready = mac_axis.tready;

    logic                    beat;
    logic                    tlast;
    logic [DATA_WIDTH-1:0]   byte_in;
    logic [2*DATA_WIDTH-1:0] word;

    assign beat    = user_axis.tvalid && mac_axis.tready;
    assign tlast   = user_axis.tlast;
    assign byte_in = user_axis.tdata;

    state_t                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] prev_q;
    logic                  vlan_q, vlan_d;
    logic                  ptp_q, ptp_d;
    logic                  event_q, event_d;
    logic                  hdr_done_q, hdr_done_d;
    logic [3:0]            msg_q, msg_d;
    logic [15:0]           seq_q, seq_d;
    logic [63:0]           tcap_q, tcap_d;
    logic                  push;

    logic [5:0] base;
    logic [5:0] base_m1;
    logic       vlan_hit;

    // Previous byte pairs with the current one so 16-bit fields compare in a single beat.
    assign word     = {prev_q, byte_in};
    assign base     = vlan_q ? 6'd18 : 6'd14;
    assign base_m1  = base - 6'd1;
    assign vlan_hit = (cnt_q == 6'd13) && (word == 16'h8100);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        vlan_d     = vlan_q;
        ptp_d      = ptp_q;
        event_d    = event_q;
        hdr_done_d = hdr_done_q;
        msg_d      = msg_q;
        seq_d      = seq_q;
        tcap_d     = tcap_q;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    tcap_d     = rtc_timer_in + TS_OFFSET;
                    cnt_d      = 6'd1;
                    vlan_d     = 1'b0;
                    ptp_d      = 1'b0;
                    event_d    = 1'b0;
                    hdr_done_d = 1'b0;
                    msg_d      = 4'd0;
                    seq_d      = 16'd0;
                    if (!tlast) state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (beat) begin
                    cnt_d = (cnt_q == 6'd63) ? 6'd63 : cnt_q + 6'd1;
                    if (vlan_hit) begin
                        vlan_d = 1'b1;
                    end else if (cnt_q == base_m1) begin
                        if (word == 16'h88F7) ptp_d   = 1'b1;
                        else                  state_d = S_PAYLOAD;
                    end
                    if (cnt_q == base) begin
                        msg_d   = byte_in[3:0];
                        event_d = ptp_q && (byte_in[3:0] < 4'd4);
                    end
                    if (cnt_q == base + 6'd31) begin
                        seq_d      = word;
                        hdr_done_d = 1'b1;
                        state_d    = S_PAYLOAD;
                    end
                    // A frame may end on its very last header byte; use the updated flags.
                    if (tlast) begin
                        state_d = S_IDLE;
                        push    = event_d && hdr_done_d;
                    end
                end
            end
            S_PAYLOAD: begin
                if (beat && tlast) begin
                    state_d = S_IDLE;
                    push    = event_q && hdr_done_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge mac_axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 6'd0;
            prev_q     <= '0;
            vlan_q     <= 1'b0;
            ptp_q      <= 1'b0;
            event_q    <= 1'b0;
            hdr_done_q <= 1'b0;
            msg_q      <= 4'd0;
            seq_q      <= 16'd0;
            tcap_q     <= 64'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            if (beat) prev_q <= byte_in;
            vlan_q     <= vlan_d;
            ptp_q      <= ptp_d;
            event_q    <= event_d;
            hdr_done_q <= hdr_done_d;
            msg_q      <= msg_d;
            seq_q      <= seq_d;
            tcap_q     <= tcap_d;
        end
    end

    rec_t            mem [FIFO_DEPTH];
    rec_t            new_rec;
    rec_t            head_q, head_d;
    logic            valid_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [15:0]     ovf_q;
    logic            pop, full, push_ok, drop;

    assign new_rec = '{t: tcap_q, mt: msg_d, seq: seq_d, vlan: vlan_d};
    assign pop     = valid_q && ts_ready;
    assign full    = (count_q == DEPTH_C);
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    // Head register is loaded from the next read slot; a push into an otherwise
    // empty queue bypasses storage so it is visible the cycle after tlast.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)      count_d = count_q + CNT_ONE;
        else if (!push_ok && pop) count_d = count_q - CNT_ONE;
        head_d = head_q;
        if (count_d != '0) begin
            if (push_ok && (rd_ptr_d == wr_ptr_q)) head_d = new_rec;
            else                                   head_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge mac_axis_aclk) begin
        if (push_ok) mem[wr_ptr_q] <= new_rec;
    end

    always_ff @(posedge mac_axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
            ovf_q    <= 16'd0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= (count_d != '0);
            head_q   <= head_d;
            if (drop && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 16'd1;
        end
    end

    assign ts_valid        = valid_q;
    assign ts_time         = head_q.t;
    assign ts_msg_type     = head_q.mt;
    assign ts_seq_id       = head_q.seq;
    assign ts_vlan         = head_q.vlan;
    assign ts_overflow_cnt = ovf_q;

endmodule
